// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit.
// Size encodings, FSM states and default memory depth.
package lsu_pkg;

  localparam int DEF_MEM_WORDS = 100;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    MERGE = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } state_e;

  function automatic logic is_sub_word(
    input logic [1:0] sz
  );
    return (sz == SZ_BYTE) || (sz == SZ_HALF);
  endfunction

endpackage

// File: rtl/lsu_lane_format.sv
// Little-endian lane extract/extend for loads
// and read-modify-write lane merge for stores.
module lsu_lane_format
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  lane,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  b_sel;
  logic [15:0] h_sel;

  // Pick the addressed byte and half from the read word
  always_comb begin
    b_sel = 8'h00;
    unique case (lane)
      2'd0: b_sel = rdata[7:0];
      2'd1: b_sel = rdata[15:8];
      2'd2: b_sel = rdata[23:16];
      2'd3: b_sel = rdata[31:24];
    endcase
    h_sel = lane[1] ? rdata[31:16] : rdata[15:0];
  end

  // Load formatting and store lane merge; size 11 acts as word
  always_comb begin
    load_data  = rdata;
    store_data = wdata;
    unique case (1'b1)
      (size == SZ_BYTE): begin
        load_data  = {{24{sign_ext & b_sel[7]}}, b_sel};
        store_data = rdata;
        store_data[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      (size == SZ_HALF): begin
        load_data  = {{16{sign_ext & h_sel[15]}}, h_sel};
        store_data = rdata;
        store_data[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_data  = rdata;
        store_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit with sub-word RMW stores.
// Optional alignment faults via LSU_ALIGN_CHECK_EN.
module mem_access_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = DEF_MEM_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        mem_wr,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  state_e state;
  state_e state_nxt;

  logic       we_q;
  logic [1:0] size_q;
  logic       sign_q;
  logic [1:0] lane_q;

  logic        accept;
  logic        range_bad;
  logic        align_bad;
  logic        fault_in;
  logic [31:0] load_data;
  logic [31:0] store_data;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign mem_wr     = (state == WRITE) && !rst;
  assign accept     = req_valid && req_ready;

  assign range_bad =
    {2'b00, req_addr[31:2]} >= 32'(MEM_WORDS);

`ifdef LSU_ALIGN_CHECK_EN
  assign align_bad =
    ((req_size == SZ_HALF) && req_addr[0]) ||
    (!is_sub_word(req_size) && (req_addr[1:0] != 2'b00));
`else
  assign align_bad = 1'b0;
`endif

  assign fault_in = range_bad || align_bad;

  lsu_lane_format u_fmt (
    .size       (size_q),
    .sign_ext   (sign_q),
    .lane       (lane_q),
    .rdata      (mem_data_out),
    .wdata      (mem_data_in),
    .load_data  (load_data),
    .store_data (store_data)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state sequencing per access kind
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (fault_in)
            state_nxt = RESP;
          else if (!req_we || is_sub_word(req_size))
            state_nxt = READ;
          else
            state_nxt = WRITE;
        end
      end
      READ:  state_nxt = MERGE;
      MERGE: state_nxt = we_q ? WRITE : RESP;
      WRITE: state_nxt = RESP;
      RESP:  if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, merged store data and response data
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      sign_q      <= 1'b0;
      lane_q      <= 2'b00;
      mem_address <= 32'h0;
      mem_data_in <= 32'h0;
      resp_rdata  <= 32'h0;
      resp_fault  <= 1'b0;
    end else begin
      if (accept) begin
        we_q        <= req_we;
        size_q      <= req_size;
        sign_q      <= req_signed;
        lane_q      <= req_addr[1:0];
        mem_address <= {2'b00, req_addr[31:2]};
        mem_data_in <= req_wdata;
        resp_rdata  <= 32'h0;
        resp_fault  <= fault_in;
      end
      if (state == MERGE) begin
        if (we_q) mem_data_in <= store_data;
        else      resp_rdata  <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit.
// Includes a falling-edge-write data memory model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_wr;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;

  logic [31:0] mem [0:99];
  int total = 0;
  int bad = 0;
  int wr_cnt = 0;

  int          lat;
  logic [31:0] rd;
  logic        ft;
  int          w0;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_WORDS(100)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_fault   (resp_fault),
    .mem_wr       (mem_wr),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  // Data memory: write on falling edge, registered read on rising edge
  always @(negedge clk) begin
    if (mem_wr === 1'b1 && mem_address < 100)
      mem[mem_address[6:0]] <= mem_data_in;
  end

  always @(posedge clk) begin
    if (mem_wr !== 1'b1)
      mem_data_out <= (mem_address < 100) ?
        mem[mem_address[6:0]] : 32'h0;
  end

  always @(posedge clk) begin
    if (mem_wr === 1'b1) wr_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic we,
                        input logic [1:0] sz,
                        input logic sg,
                        input logic [31:0] a,
                        input logic [31:0] wd,
                        input int hold,
                        input logic [31:0] hexp,
                        output int l,
                        output logic [31:0] r,
                        output logic f);
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    l = 1;
    while (resp_valid !== 1'b1 && l < 20) begin
      @(negedge clk);
      l++;
    end
    chk("resp_seen", {31'b0, resp_valid}, 32'd1);
    r = resp_rdata;
    f = resp_fault;
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", {31'b0, resp_valid}, 32'd1);
      chk("hold_rdata", resp_rdata, hexp);
      chk("hold_ready", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 100; i++) mem[i] = 32'h0;
    mem_data_out = 32'h0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'b10;
    req_signed = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_fault", {31'b0, resp_fault}, 32'd0);
    chk("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
    chk("rst_addr", mem_address, 32'h0);
    chk("rst_din", mem_data_in, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    w0 = wr_cnt;
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF,
           0, 0, lat, rd, ft);
    chk("wst_lat", 32'(lat), 32'd2);
    chk("wst_fault", {31'b0, ft}, 32'd0);
    chk("wst_rdata", rd, 32'h0);
    chk("wst_mem", mem[4], 32'hDEADBEEF);
    chk("wst_pulses", 32'(wr_cnt - w0), 32'd1);

    w0 = wr_cnt;
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,
           0, 0, lat, rd, ft);
    chk("wld_lat", 32'(lat), 32'd3);
    chk("wld_rdata", rd, 32'hDEADBEEF);
    chk("wld_nowr", 32'(wr_cnt - w0), 32'd0);

    w0 = wr_cnt;
    do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'hAAAA557F,
           0, 0, lat, rd, ft);
    chk("bst_lat", 32'(lat), 32'd4);
    chk("bst_mem", mem[4], 32'hDEAD7FEF);
    chk("bst_pulses", 32'(wr_cnt - w0), 32'd1);

    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0,
           0, 0, lat, rd, ft);
    chk("bld_s", rd, 32'hFFFFFFDE);
    do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0,
           0, 0, lat, rd, ft);
    chk("bld_u", rd, 32'h000000DE);
    do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0,
           0, 0, lat, rd, ft);
    chk("bld_s_pos", rd, 32'h0000007F);

    w0 = wr_cnt;
    do_req(1'b0, 2'b10, 1'b0, 32'h190, 32'h0,
           0, 0, lat, rd, ft);
    chk("oor_lat", 32'(lat), 32'd1);
    chk("oor_fault", {31'b0, ft}, 32'd1);
    chk("oor_rdata", rd, 32'h0);
    do_req(1'b1, 2'b00, 1'b0, 32'h190, 32'h11,
           0, 0, lat, rd, ft);
    chk("oor_st_fault", {31'b0, ft}, 32'd1);
    chk("oor_nowr", 32'(wr_cnt - w0), 32'd0);

    do_req(1'b1, 2'b10, 1'b0, 32'h18C, 32'h12345678,
           0, 0, lat, rd, ft);
    chk("last_fault", {31'b0, ft}, 32'd0);
    chk("last_mem", mem[99], 32'h12345678);

    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h55667788,
           0, 0, lat, rd, ft);
    do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000ABCD,
           0, 0, lat, rd, ft);
    chk("hst_lat", 32'(lat), 32'd4);
    chk("hst_mem", mem[8], 32'hABCD7788);
    do_req(1'b0, 2'b01, 1'b1, 32'h22, 32'h0,
           0, 0, lat, rd, ft);
    chk("hld_s", rd, 32'hFFFFABCD);
    do_req(1'b0, 2'b01, 1'b1, 32'h20, 32'h0,
           0, 0, lat, rd, ft);
    chk("hld_s_pos", rd, 32'h00007788);

    do_req(1'b0, 2'b01, 1'b0, 32'h21, 32'h0,
           0, 0, lat, rd, ft);
`ifdef LSU_ALIGN_CHECK_EN
    chk("mis21_fault", {31'b0, ft}, 32'd1);
    chk("mis21_lat", 32'(lat), 32'd1);
    chk("mis21_rdata", rd, 32'h0);
`else
    chk("mis21_fault", {31'b0, ft}, 32'd0);
    chk("mis21_rdata", rd, 32'h00007788);
`endif
    do_req(1'b0, 2'b01, 1'b0, 32'h23, 32'h0,
           0, 0, lat, rd, ft);
`ifdef LSU_ALIGN_CHECK_EN
    chk("mis23_fault", {31'b0, ft}, 32'd1);
`else
    chk("mis23_rdata", rd, 32'h0000ABCD);
`endif
    do_req(1'b0, 2'b10, 1'b0, 32'h12, 32'h0,
           0, 0, lat, rd, ft);
`ifdef LSU_ALIGN_CHECK_EN
    chk("misw_fault", {31'b0, ft}, 32'd1);
`else
    chk("misw_rdata", rd, 32'hDEAD7FEF);
`endif

    resp_ready = 1'b0;
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,
           5, 32'hDEAD7FEF, lat, rd, ft);
    chk("stall_rdata", rd, 32'hDEAD7FEF);
    chk("stall_idle", {31'b0, req_ready}, 32'd1);

    w0 = wr_cnt;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_size   = 2'b01;
    req_signed = 1'b0;
    req_addr   = 32'h20;
    req_wdata  = 32'h00001111;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_mem_wr", {31'b0, mem_wr}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_idle", {31'b0, req_ready}, 32'd1);
    chk("abort_no_resp", {31'b0, resp_valid}, 32'd0);
    repeat (3) @(negedge clk);
    chk("abort_no_resp2", {31'b0, resp_valid}, 32'd0);
    chk("abort_mem", mem[8], 32'hABCD7788);
    chk("abort_nowr", 32'(wr_cnt - w0), 32'd0);

    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0,
           0, 0, lat, rd, ft);
    chk("post_abort_ld", rd, 32'hABCD7788);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
